// File: rtl/decode_stage.sv
// Registered RV32I decode stage: field split, immediate build and legality check behind a
// valid/ready handshake with stall and flush. Optional perf counters via DECODE_PERF_CNT_EN.
module decode_stage #(
    parameter int XLEN    = 32,
    parameter int IMEM_AW = 20,
    parameter int DMEM_AW = 10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [31:0]        instr_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic [XLEN-1:0]    alu_result_i,
    input  logic               flush_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [6:0]         opcode_o,
    output logic [4:0]         rd_o,
    output logic [2:0]         f3_o,
    output logic [4:0]         rs1_o,
    output logic [4:0]         rs2_o,
    output logic               f7_o,
    output logic [XLEN-1:0]    imm_o,
    output logic               illegal_o,
    output logic [XLEN-1:0]    pc_o,
    output logic [IMEM_AW-1:0] imem_addr_o,
    output logic [DMEM_AW-1:0] dmem_addr_o
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]        dec_count_o,
    output logic [31:0]        stall_count_o
`endif
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    function automatic logic signed [31:0] imm_gen(input logic [31:0] ins);
        logic signed [31:0] imm;
        imm = '0;
        case (ins[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM:
                imm = {{20{ins[31]}}, ins[31:20]};
            OPC_STORE:
                imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OPC_BRANCH:
                imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {ins[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default:
                imm = '0;
        endcase
        return imm;
    endfunction

    function automatic logic is_illegal(input logic [31:0] ins);
        logic [2:0] f3;
        logic [6:0] f7;
        logic       bad;
        f3  = ins[14:12];
        f7  = ins[31:25];
        bad = 1'b0;
        case (ins[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_MISC, OPC_SYSTEM: bad = 1'b0;
            OPC_JALR:   bad = (f3 != 3'b000);
            OPC_BRANCH: bad = (f3 == 3'b010) || (f3 == 3'b011);
            OPC_LOAD:   bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            OPC_STORE:  bad = (f3 > 3'b010);
            OPC_OPIMM:  bad = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
                              ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
            OPC_OP:     bad = ((f7 != 7'b0000000) && (f7 != 7'b0100000)) ||
                              ((f7 == 7'b0100000) && (f3 != 3'b000) && (f3 != 3'b101));
            default:    bad = 1'b1;
        endcase
        if (ins[1:0] != 2'b11) bad = 1'b1;
        return bad;
    endfunction

    logic            valid_q, valid_d;
    logic [6:0]      opcode_q;
    logic [4:0]      rd_q, rs1_q, rs2_q;
    logic [2:0]      f3_q;
    logic            f7_q;
    logic [XLEN-1:0] imm_q, pc_q;
    logic            illegal_q;
    logic            load;
    logic signed [31:0]     imm32;
    logic signed [XLEN-1:0] imm_ext;
    logic            unused_alu_bits;

    assign in_ready_o = !valid_q || out_ready_i;
    assign load       = in_valid_i && in_ready_o && !flush_i;
    assign imm32      = imm_gen(instr_i);
    assign imm_ext    = XLEN'(imm32);

    // Flush outranks both load and hold.
    always_comb begin
        valid_d = valid_q;
        if (flush_i)          valid_d = 1'b0;
        else if (load)        valid_d = 1'b1;
        else if (out_ready_i) valid_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            rd_q      <= '0;
            f3_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            f7_q      <= 1'b0;
            imm_q     <= '0;
            illegal_q <= 1'b0;
            pc_q      <= '0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                opcode_q  <= instr_i[6:0];
                rd_q      <= instr_i[11:7];
                f3_q      <= instr_i[14:12];
                rs1_q     <= instr_i[19:15];
                rs2_q     <= instr_i[24:20];
                f7_q      <= instr_i[30];
                imm_q     <= imm_ext;
                illegal_q <= is_illegal(instr_i);
                pc_q      <= pc_i;
            end
        end
    end

    assign out_valid_o = valid_q;
    assign opcode_o    = opcode_q;
    assign rd_o        = rd_q;
    assign f3_o        = f3_q;
    assign rs1_o       = rs1_q;
    assign rs2_o       = rs2_q;
    assign f7_o        = f7_q;
    assign imm_o       = imm_q;
    assign illegal_o   = illegal_q;
    assign pc_o        = pc_q;

    assign imem_addr_o     = pc_i[IMEM_AW+1:2];
    assign dmem_addr_o     = alu_result_i[DMEM_AW-1:0];
    assign unused_alu_bits = ^alu_result_i;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] dec_count_q, dec_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Counters free-run with natural 32-bit wrap and ignore flush.
    always_comb begin
        dec_count_d   = dec_count_q;
        stall_count_d = stall_count_q;
        if (valid_q && out_ready_i)  dec_count_d   = dec_count_q + 32'd1;
        if (valid_q && !out_ready_i) stall_count_d = stall_count_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dec_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            dec_count_q   <= dec_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign dec_count_o   = dec_count_q;
    assign stall_count_o = stall_count_q;
`endif

endmodule
